// File: rtl/fu_issue_dispatch_if.sv
// rtl/fu_issue_dispatch_if.sv - issue handshake and per-unit dispatch bundle for fu_issue_dispatch
// Purpose: groups the upstream issue handshake, the execute-stage ready inputs and the
//          one-hot dispatch outputs of fu_issue_dispatch.
// Signals:
//   issue_valid_i / issue_ready_o / issue_fu_i / issue_tid_i   upstream offer handshake
//   flu_ready_i / lsu_ready_i / fpu_ready_i                    execute-stage unit readiness
//   alu/branch/csr/mult/lsu/fpu_valid_o, trans_id_o             one-hot dispatch to ex_stage
// Modports: master = issue/execute side driving the offer and readies; slave = the dispatcher.
interface fu_issue_dispatch_if #(
   parameter int unsigned TransIdBits = 3
);
   logic                   issue_valid_i;
   logic                   issue_ready_o;
   logic [3:0]             issue_fu_i;
   logic [TransIdBits-1:0] issue_tid_i;
   logic                   flu_ready_i;
   logic                   lsu_ready_i;
   logic                   fpu_ready_i;
   logic                   alu_valid_o;
   logic                   branch_valid_o;
   logic                   csr_valid_o;
   logic                   mult_valid_o;
   logic                   lsu_valid_o;
   logic                   fpu_valid_o;
   logic [TransIdBits-1:0] trans_id_o;

   modport master (
      output issue_valid_i, issue_fu_i, issue_tid_i, flu_ready_i, lsu_ready_i, fpu_ready_i,
      input  issue_ready_o, alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o,
             lsu_valid_o, fpu_valid_o, trans_id_o
   );

   modport slave (
      input  issue_valid_i, issue_fu_i, issue_tid_i, flu_ready_i, lsu_ready_i, fpu_ready_i,
      output issue_ready_o, alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o,
             lsu_valid_o, fpu_valid_o, trans_id_o
   );
endinterface

// File: rtl/fu_issue_dispatch.sv
// rtl/fu_issue_dispatch.sv - single-slot execute-stage issue dispatcher with FLU write-back collision guard
// Purpose: holds one issued instruction {fu, tid} and raises exactly one per-unit valid when the
//          target unit is ready. Fixed-latency ops (ALU/branch/CSR) are held back in the cycle a
//          pending multiplier result occupies the shared FLU write-back port.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous reset, active low
//   flush_i      drop held instruction and multiplier reservations
//   bus          fu_issue_dispatch_if.slave: issue handshake, unit readies, one-hot dispatch
//   stall_cnt_o  stall-cycle counter (32 bits)
// Optional feature: FU_ISSUE_STALL_CNT_EN enables the saturating stall counter; otherwise
//          stall_cnt_o is constant 0.
module fu_issue_dispatch #(
   parameter int unsigned MulLatency  = 1,
   parameter int unsigned TransIdBits = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   fu_issue_dispatch_if.slave       bus,
   output logic [31:0]              stall_cnt_o
);

   // ariane_pkg::fu_t encodings
   localparam logic [3:0] FU_LOAD      = 4'd1;
   localparam logic [3:0] FU_STORE     = 4'd2;
   localparam logic [3:0] FU_ALU       = 4'd3;
   localparam logic [3:0] FU_CTRL_FLOW = 4'd4;
   localparam logic [3:0] FU_MULT      = 4'd5;
   localparam logic [3:0] FU_CSR       = 4'd6;
   localparam logic [3:0] FU_FPU       = 4'd7;
   localparam logic [3:0] FU_FPU_VEC   = 4'd8;

   logic                   slot_valid_q;
   logic [3:0]             slot_fu_q;
   logic [TransIdBits-1:0] slot_tid_q;

   // Bit i set: a multiplier result lands on the FLU write-back port i cycles from now.
   logic [MulLatency-1:0]  wb_busy_q;
   logic [MulLatency-1:0]  wb_busy_d;

   logic alu_v, branch_v, csr_v, mult_v, lsu_v, fpu_v;
   logic retire_none;
   logic flu_free;
   logic fire;
   logic ready;
   logic accept;

   always_comb begin
      alu_v       = 1'b0;
      branch_v    = 1'b0;
      csr_v       = 1'b0;
      mult_v      = 1'b0;
      lsu_v       = 1'b0;
      fpu_v       = 1'b0;
      retire_none = 1'b0;
      flu_free    = bus.flu_ready_i & ~wb_busy_q[0];
      if (slot_valid_q && !flush_i) begin
         case (slot_fu_q)
            FU_ALU:             alu_v    = flu_free;
            FU_CTRL_FLOW:       branch_v = flu_free;
            FU_CSR:             csr_v    = flu_free;
            // The multiplier's own result is scheduled later, so it never waits on wb_busy.
            FU_MULT:            mult_v   = bus.flu_ready_i;
            FU_LOAD, FU_STORE:  lsu_v    = bus.lsu_ready_i;
            FU_FPU, FU_FPU_VEC: fpu_v    = bus.fpu_ready_i;
            // NONE (and any unused encoding) needs no unit: leave the slot at once.
            default:            retire_none = 1'b1;
         endcase
      end
      fire   = alu_v | branch_v | csr_v | mult_v | lsu_v | fpu_v | retire_none;
      ready  = ~flush_i & (~slot_valid_q | fire);
      accept = bus.issue_valid_i & ready;
   end

   always_comb begin
      wb_busy_d = '0;
      for (int i = 0; i < int'(MulLatency) - 1; i++) begin
         wb_busy_d[i] = wb_busy_q[i+1];
      end
      wb_busy_d[MulLatency-1] = mult_v;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_valid_q <= 1'b0;
         slot_fu_q    <= 4'd0;
         slot_tid_q   <= '0;
         wb_busy_q    <= '0;
      end else if (flush_i) begin
         slot_valid_q <= 1'b0;
         wb_busy_q    <= '0;
      end else begin
         wb_busy_q <= wb_busy_d;
         if (accept) begin
            // Covers both empty-slot fill and dispatch-plus-refill without a bubble.
            slot_valid_q <= 1'b1;
            slot_fu_q    <= bus.issue_fu_i;
            slot_tid_q   <= bus.issue_tid_i;
         end else if (fire) begin
            slot_valid_q <= 1'b0;
         end
      end
   end

   assign bus.issue_ready_o  = ready;
   assign bus.alu_valid_o    = alu_v;
   assign bus.branch_valid_o = branch_v;
   assign bus.csr_valid_o    = csr_v;
   assign bus.mult_valid_o   = mult_v;
   assign bus.lsu_valid_o    = lsu_v;
   assign bus.fpu_valid_o    = fpu_v;
   assign bus.trans_id_o     = slot_tid_q;

`ifdef FU_ISSUE_STALL_CNT_EN
   logic        stall;
   logic [31:0] stall_cnt_q;

   assign stall = slot_valid_q & ~fire & ~flush_i;

   // Counts across flushes; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= 32'd0;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'd0;
`endif

   logic [5:0] valid_vec;
   assign valid_vec = {fpu_v, lsu_v, mult_v, csr_v, branch_v, alu_v};

   valid_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(valid_vec));

   valid_needs_slot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !slot_valid_q |-> (valid_vec == 6'd0));

endmodule
